// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler that shares one combinational 16-bit ALU among NUM_REQ cores.
// Operands are registered at grant. The result is captured one cycle later and returned with a one-cycle ack.
module alu_share_ctrl #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [3*NUM_REQ-1:0]    op_flat,
    input  logic [16*NUM_REQ-1:0]   bus_flat,
    input  logic [16*NUM_REQ-1:0]   ac_flat,
    output logic [2:0]              alu_operation,
    output logic [15:0]             alu_in_bus,
    output logic [15:0]             alu_in_AC,
    input  logic [15:0]             alu_data_out,
    output logic [NUM_REQ-1:0]      ack,
    output logic [15:0]             result,
    output logic [ID_W-1:0]         result_id,
    output logic                    div_zero,
    output logic                    busy
);

    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 16;
    localparam logic [OP_W-1:0] OP_DIV = 3'd4;
    localparam logic [OP_W-1:0] OP_MOD = 3'd5;

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     ptr_d;
    logic [ID_W-1:0]     gid;
    logic [ID_W-1:0]     gid_d;
    logic [ID_W-1:0]     win;
    logic [ID_W-1:0]     idx;
    logic                found;
    logic [NUM_REQ-1:0]  eff;
    logic [NUM_REQ-1:0]  ack_d;
    logic [OP_W-1:0]     op_d;
    logic [DATA_W-1:0]   bus_d;
    logic [DATA_W-1:0]   ac_d;
    logic [DATA_W-1:0]   result_d;
    logic [ID_W-1:0]     result_id_d;
    logic                div_zero_d;
    logic                busy_d;
    logic                zero_div;

    // The ALU does not guard divide and modulo by zero, so a zero divisor is blocked here.
    assign zero_div = ((alu_operation == OP_DIV) || (alu_operation == OP_MOD))
                      && (alu_in_bus == '0);

    // Next-state, arbitration and next-value logic for every register.
    always_comb begin
        state_next  = state;
        ptr_d       = ptr;
        gid_d       = gid;
        op_d        = alu_operation;
        bus_d       = alu_in_bus;
        ac_d        = alu_in_AC;
        ack_d       = '0;
        div_zero_d  = 1'b0;
        result_d    = result;
        result_id_d = result_id;
        win         = ptr;
        idx         = '0;
        found       = 1'b0;

        // A core that is being acked this cycle is masked, so it cannot win again immediately.
        eff = req & ~ack;

        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && eff[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_next = EXEC;
                    gid_d      = win;
                    for (int i = 0; i < int'(NUM_REQ); i++) begin
                        if (win == ID_W'(i)) begin
                            op_d  = op_flat[3*i +: 3];
                            bus_d = bus_flat[16*i +: 16];
                            ac_d  = ac_flat[16*i +: 16];
                        end
                    end
                end
            end
            EXEC: begin
                state_next  = IDLE;
                result_id_d = gid;
                ptr_d       = ID_W'((32'(gid) + 32'd1) % NUM_REQ);
                if (zero_div) begin
                    result_d   = '0;
                    div_zero_d = 1'b1;
                end else begin
                    result_d   = alu_data_out;
                end
                for (int i = 0; i < int'(NUM_REQ); i++) begin
                    ack_d[i] = (gid == ID_W'(i));
                end
            end
            default: state_next = IDLE;
        endcase

        busy_d = (state_next == EXEC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            gid           <= '0;
            alu_operation <= '0;
            alu_in_bus    <= '0;
            alu_in_AC     <= '0;
            ack           <= '0;
            div_zero      <= 1'b0;
            result        <= '0;
            result_id     <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            ptr           <= ptr_d;
            gid           <= gid_d;
            alu_operation <= op_d;
            alu_in_bus    <= bus_d;
            alu_in_AC     <= ac_d;
            ack           <= ack_d;
            div_zero      <= div_zero_d;
            result        <= result_d;
            result_id     <= result_id_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: a transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_share_ctrl;

    localparam int unsigned N   = 4;
    localparam int unsigned IDW = $clog2(N);

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req;
    logic [3*N-1:0]      op_flat;
    logic [16*N-1:0]     bus_flat;
    logic [16*N-1:0]     ac_flat;
    logic [2:0]          alu_operation;
    logic [15:0]         alu_in_bus;
    logic [15:0]         alu_in_AC;
    logic [15:0]         alu_data_out;
    logic [N-1:0]        ack;
    logic [15:0]         result;
    logic [IDW-1:0]      result_id;
    logic                div_zero;
    logic                busy;

    logic [2:0]          op_a  [N];
    logic [15:0]         bus_a [N];
    logic [15:0]         ac_a  [N];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    alu_share_ctrl #(.NUM_REQ(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .op_flat       (op_flat),
        .bus_flat      (bus_flat),
        .ac_flat       (ac_flat),
        .alu_operation (alu_operation),
        .alu_in_bus    (alu_in_bus),
        .alu_in_AC     (alu_in_AC),
        .alu_data_out  (alu_data_out),
        .ack           (ack),
        .result        (result),
        .result_id     (result_id),
        .div_zero      (div_zero),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            op_flat[3*i +: 3]   = op_a[i];
            bus_flat[16*i +: 16] = bus_a[i];
            ac_flat[16*i +: 16]  = ac_a[i];
        end
    end

    // Shared ALU: a zero divisor yields garbage so that the controller's override is observable.
    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] b,
                                           input logic [15:0] a);
        logic [15:0] r;
        case (op)
            3'd1:    r = a * b;
            3'd2:    r = a + b;
            3'd3:    r = a - b;
            3'd4:    r = (b == 16'd0) ? 16'hBEEF : a / b;
            3'd5:    r = (b == 16'd0) ? 16'hBEEF : a % b;
            default: r = b;
        endcase
        return r;
    endfunction

    always_comb alu_data_out = alu_fn(alu_operation, alu_in_bus, alu_in_AC);

    // Reference model: a job is taken at a free edge and completes at the following edge.
    int           m_ptr;
    bit           m_serving;
    int           m_gid;
    logic [2:0]   m_op;
    logic [15:0]  m_bus;
    logic [15:0]  m_ac;
    logic [N-1:0] m_ack;
    logic [15:0]  m_result;
    int           m_rid;
    bit           m_dz;
    logic [N-1:0] m_eff;
    bit           m_found;
    int           m_c;

    always @(posedge clk) begin
        if (rst) begin
            m_ptr = 0; m_serving = 0; m_gid = 0; m_op = '0; m_bus = '0; m_ac = '0;
            m_ack = '0; m_result = '0; m_rid = 0; m_dz = 0;
        end else if (m_serving) begin
            if ((m_op == 3'd4 || m_op == 3'd5) && m_bus == 16'd0) begin
                m_result = 16'd0;
                m_dz     = 1'b1;
            end else begin
                m_result = alu_fn(m_op, m_bus, m_ac);
                m_dz     = 1'b0;
            end
            m_rid        = m_gid;
            m_ack        = '0;
            m_ack[m_gid] = 1'b1;
            m_ptr        = (m_gid + 1) % int'(N);
            m_serving    = 1'b0;
        end else begin
            m_eff   = req & ~m_ack;
            m_ack   = '0;
            m_dz    = 1'b0;
            m_found = 1'b0;
            for (int k = 0; k < int'(N); k++) begin
                m_c = (m_ptr + k) % int'(N);
                if (!m_found && m_eff[m_c]) begin
                    m_found   = 1'b1;
                    m_gid     = m_c;
                    m_op      = op_a[m_c];
                    m_bus     = bus_a[m_c];
                    m_ac      = ac_a[m_c];
                    m_serving = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, all DUT outputs must equal the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ack",           64'(ack),           64'(m_ack));
            check("result",        64'(result),        64'(m_result));
            check("result_id",     64'(result_id),     64'(m_rid));
            check("div_zero",      64'(div_zero),      64'(m_dz));
            check("busy",          64'(busy),          64'(m_serving));
            check("alu_operation", 64'(alu_operation), 64'(m_op));
            check("alu_in_bus",    64'(alu_in_bus),    64'(m_bus));
            check("alu_in_AC",     64'(alu_in_AC),     64'(m_ac));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_core(input int i, input logic [2:0] op, input logic [15:0] ac,
                            input logic [15:0] bus);
        op_a[i]  = op;
        ac_a[i]  = ac;
        bus_a[i] = bus;
        req[i]   = 1'b1;
    endtask

    task automatic wait_ack(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (ack == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (ack == '0) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    int prev_cyc;
    int exp_id;
    logic [2:0]  t4_op  [4];
    logic [15:0] t4_ac  [4];
    logic [15:0] t4_bus [4];
    logic [15:0] t4_res [4];
    logic        t4_dz  [4];

    initial begin
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < int'(N); i++) begin
            op_a[i] = '0; bus_a[i] = '0; ac_a[i] = '0;
        end

        // Reset values, then a single multiply from core 0.
        do_reset();
        chk_en = 1'b1;
        check("rst_ack",    64'(ack),        64'd0);
        check("rst_result", 64'(result),     64'd0);
        check("rst_busy",   64'(busy),       64'd0);
        check("rst_alu_op", 64'(alu_operation), 64'd0);
        set_core(0, 3'd1, 16'd3, 16'd5);
        @(negedge clk);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_noack", 64'(ack), 64'd0);
        @(negedge clk);
        check("t1_ack",       64'(ack),       64'b0001);
        check("t1_result",    64'(result),    64'd15);
        check("t1_result_id", 64'(result_id), 64'd0);
        check("t1_div_zero",  64'(div_zero),  64'd0);
        check("t1_model_pin", 64'(m_result),  64'd15);
        req[0] = 1'b0;

        // Four simultaneous adds are served in index order, two cycles apart.
        do_reset();
        for (int i = 0; i < 4; i++) set_core(i, 3'd2, 16'(i), 16'd10);
        prev_cyc = 0;
        for (int e = 0; e < 4; e++) begin
            wait_ack(6, "t2");
            check("t2_ack_order", 64'(ack),    64'(4'b0001 << e));
            check("t2_result",    64'(result), 64'(10 + e));
            if (e > 0) check("t2_spacing", 64'(cyc - prev_cyc), 64'd2);
            prev_cyc = cyc;
            req[e]   = 1'b0;
        end

        // After core 1, cores 0 and 2 hold requests and must alternate 2, 0, 2, 0.
        do_reset();
        set_core(1, 3'd2, 16'd1, 16'd1);
        wait_ack(6, "t3a");
        check("t3_first", 64'(ack), 64'b0010);
        req[1] = 1'b0;
        set_core(0, 3'd2, 16'd0, 16'd0);
        set_core(2, 3'd2, 16'd0, 16'd2);
        for (int e = 0; e < 4; e++) begin
            exp_id = (e % 2 == 0) ? 2 : 0;
            wait_ack(6, "t3");
            check("t3_alternate", 64'(ack), 64'(4'b0001 << exp_id));
        end
        req = '0;

        // Core 3 divide, modulo, wrap-around subtract and divide by zero.
        t4_op  = '{3'd4, 3'd5, 3'd3, 3'd4};
        t4_ac  = '{16'd17, 16'd17, 16'd3, 16'd17};
        t4_bus = '{16'd5, 16'd5, 16'd5, 16'd0};
        t4_res = '{16'd3, 16'd2, 16'hFFFE, 16'd0};
        t4_dz  = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int e = 0; e < 4; e++) begin
            set_core(3, t4_op[e], t4_ac[e], t4_bus[e]);
            wait_ack(6, "t4");
            check("t4_ack",      64'(ack),      64'b1000);
            check("t4_result",   64'(result),   64'(t4_res[e]));
            check("t4_div_zero", 64'(div_zero), 64'(t4_dz[e]));
            req[3] = 1'b0;
        end
        check("t4_model_pin", 64'(m_dz), 64'd1);

        // Core 2's inputs change and its req drops after grant; the granted operands are used.
        set_core(2, 3'd2, 16'd100, 16'd7);
        @(negedge clk);
        check("t5_busy", 64'(busy), 64'd1);
        op_a[2] = 3'd1; ac_a[2] = 16'd1; bus_a[2] = 16'd1; req[2] = 1'b0;
        @(negedge clk);
        check("t5_ack",       64'(ack),       64'b0100);
        check("t5_result",    64'(result),    64'd107);
        check("t5_result_id", 64'(result_id), 64'd2);

        // A reset during EXEC abandons the job; the held request is served again afterwards.
        set_core(1, 3'd1, 16'd6, 16'd7);
        @(negedge clk);
        check("t6_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_ack",    64'(ack),        64'd0);
        check("t6_rst_busy",   64'(busy),       64'd0);
        check("t6_rst_result", 64'(result),     64'd0);
        check("t6_rst_rid",    64'(result_id),  64'd0);
        check("t6_rst_bus",    64'(alu_in_bus), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t6_regrant", 64'(busy), 64'd1);
        check("t6_noack",   64'(ack),  64'd0);
        @(negedge clk);
        check("t6_ack",    64'(ack),    64'b0010);
        check("t6_result", 64'(result), 64'd42);
        req[1] = 1'b0;

        // Randomized traffic with withdrawals, late operand changes and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < int'(N); i++) begin
                if (req[i] && m_ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    op_a[i]  = 3'($urandom_range(0, 7));
                    bus_a[i] = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
                    ac_a[i]  = 16'($urandom);
                    req[i]   = 1'b1;
                end else if (req[i] && $urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    ac_a[i]  = 16'($urandom);
                    bus_a[i] = 16'($urandom_range(0, 3));
                end
            end
        end
        rst = 1'b0;
        req = '0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
